// File: rtl/signed_divider.sv
// Iterative signed divider: restoring division on magnitudes, one quotient bit per clock,
// with sign correction and b==0 / MIN÷-1 special results; valid/ready on both sides.
module signed_divider #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] q,
  output logic signed [WIDTH-1:0] r,
  output logic                    div_by_zero,
  output logic                    overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;      // raw operands kept for signs and special cases
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;  // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    bmag_d  = bmag_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    a_mag = a[WIDTH-1] ? -a : a;
    b_mag = b[WIDTH-1] ? -b : b;

    // The true difference is < |b| whenever taken, so WIDTH-bit wraparound is exact.
    trial = {rem_q, dvd_q[WIDTH-1]};
    ge    = trial >= {1'b0, bmag_q};
    diff  = trial[WIDTH-1:0] - bmag_q;

    q_fix = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -dvd_q : dvd_q;
    r_fix = a_q[WIDTH-1] ? -rem_q : rem_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          bmag_d  = b_mag;
          dvd_d   = a_mag;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        rem_d = ge ? diff : trial[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        dbz_d = 1'b0;
        ovf_d = 1'b0;
        if (b_q == '0) begin
          q_d   = '1;
          r_d   = a_q;
          dbz_d = 1'b1;
        end else if (a_q == MIN_VAL && b_q == '1) begin
          q_d   = MIN_VAL;
          r_d   = '0;
          ovf_d = 1'b1;
        end else begin
          q_d = q_fix;
          r_d = r_fix;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      bmag_q  <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      bmag_q  <= bmag_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign q           = q_q;
  assign r           = r_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_signed_divider.sv
// Self-checking bench for signed_divider: directed cases, stalls, mid-operation reset
// and randomized back-to-back traffic against a plain-arithmetic reference model.
module tb_signed_divider;

  localparam int W   = 32;
  localparam int LAT = W + 2;
  localparam logic signed [W-1:0] MIN = 32'sh8000_0000;

  logic                clk;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] a;
  logic signed [W-1:0] b;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] q;
  logic signed [W-1:0] r;
  logic                div_by_zero;
  logic                overflow;

  int checks = 0;
  int passed = 0;

  signed_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .q           (q),
    .r           (r),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: truncating division from the language operators, special cases by rule.
  function automatic void model(input logic signed [W-1:0] x, y,
                                output logic signed [W-1:0] eq, er,
                                output logic edbz, eovf);
    edbz = 1'b0;
    eovf = 1'b0;
    if (y == 0) begin
      eq = -1; er = x; edbz = 1'b1;
    end else if (x == MIN && y == -1) begin
      eq = MIN; er = 0; eovf = 1'b1;
    end else begin
      eq = x / y; er = x % y;
    end
  endfunction

  // Presents one operation and waits for the result; returns the latency counted in
  // cycles from the presenting cycle, or -1 if out_valid never arrived.
  task automatic issue(input logic signed [W-1:0] ta, tb_v, output int lat, output logic rdy_low,
                       output logic signed [W-1:0] gq, gr, output logic gdbz, govf);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    lat = 1;
    rdy_low = 1'b1;
    while (!out_valid && lat < 200) begin
      if (in_ready !== 1'b0) rdy_low = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (out_valid !== 1'b1) lat = -1;
    if (in_ready !== 1'b0) rdy_low = 1'b0;
    gq = q; gr = r; gdbz = div_by_zero; govf = overflow;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, div_by_zero, overflow} !== 4'b1000 || q !== 0 || r !== 0)
      $display("FAIL reset_state: rdy=%b vld=%b dbz=%b ovf=%b q=%h r=%h, required 1 0 0 0 0 0",
               in_ready, out_valid, div_by_zero, overflow, q, r);
    else passed++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic signed [W-1:0] ta[7]  = '{100, -100, 100, -100, 5, MIN, MIN};
    logic signed [W-1:0] tbv[7] = '{7, 7, -7, -7, 0, -1, 1};
    logic signed [W-1:0] xq[7]  = '{14, -14, -14, 14, 32'hFFFF_FFFF, MIN, MIN};
    logic signed [W-1:0] xr[7]  = '{2, -2, 2, -2, 5, 0, 0};
    logic [1:0]          xf[7]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00};
    int lat;
    logic rl, gd, go;
    logic signed [W-1:0] gq, gr;
    for (int i = 0; i < 7; i++) begin
      issue(ta[i], tbv[i], lat, rl, gq, gr, gd, go);
      checks++;
      if (lat != LAT) $display("FAIL latency_%0d: got %0d cycles, required %0d", i, lat, LAT);
      else passed++;
      checks++;
      if (gq !== xq[i] || gr !== xr[i] || {gd, go} !== xf[i])
        $display("FAIL directed_%0d (%0d/%0d): q=%0d r=%0d flags=%b, required q=%0d r=%0d flags=%b",
                 i, ta[i], tbv[i], gq, gr, {gd, go}, xq[i], xr[i], xf[i]);
      else passed++;
      checks++;
      if (rl !== 1'b1) $display("FAIL busy_ready_%0d: in_ready was 1 during operation, required 0", i);
      else passed++;
      release_out();
    end
  endtask

  task automatic test_stall();
    int lat;
    logic rl, gd, go;
    logic signed [W-1:0] gq, gr;
    out_ready = 1'b0;
    issue(-12345, 67, lat, rl, gq, gr, gd, go);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || q !== gq || r !== gr || q !== -184 || r !== -17)
        $display("FAIL stall_hold_%0d: vld=%b rdy=%b q=%0d r=%0d, required 1 0 q=-184 r=-17",
                 i, out_valid, in_ready, q, r);
      else passed++;
    end
    release_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || q !== -184 || r !== -17)
      $display("FAIL post_handshake: vld=%b rdy=%b q=%0d r=%0d, required 0 1 q=-184 r=-17",
               out_valid, in_ready, q, r);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int lat;
    logic rl, gd, go;
    logic signed [W-1:0] gq, gr;
    // Leave a nonzero result on the outputs first so the async clear is visible.
    issue(1000, 3, lat, rl, gq, gr, gd, go);
    release_out();
    a = 77777; b = -5; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, div_by_zero, overflow} !== 4'b1000 || q !== 0 || r !== 0)
      $display("FAIL reset_mid: rdy=%b vld=%b dbz=%b ovf=%b q=%0d r=%0d, required 1 0 0 0 0 0",
               in_ready, out_valid, div_by_zero, overflow, q, r);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_discard: out_valid=%b, required 0", out_valid);
    else passed++;
    issue(-77, 8, lat, rl, gq, gr, gd, go);
    checks++;
    if (lat != LAT || gq !== -9 || gr !== -5 || gd !== 1'b0 || go !== 1'b0)
      $display("FAIL after_reset: lat=%0d q=%0d r=%0d, required lat=%0d q=-9 r=-5", lat, gq, gr, LAT);
    else passed++;
    release_out();
  endtask

  function automatic logic signed [W-1:0] rand_small();
    int v = $urandom_range(0, 40);
    return W'(v - 20);
  endfunction

  task automatic test_back_to_back();
    int lat, stall;
    logic rl, gd, go, ed, eo;
    logic signed [W-1:0] x, y, gq, gr, eq, er;
    for (int n = 0; n < 1500; n++) begin
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 9))
        0: begin x = rand_small(); y = rand_small(); end
        1: y = 0;
        2: begin x = MIN; y = ($urandom_range(0, 1) != 0) ? -1 : rand_small(); end
        3: y = ($urandom_range(0, 1) != 0) ? W'($urandom_range(1, 255)) : -W'($urandom_range(1, 255));
        4: y = -1;
        default: ;
      endcase
      model(x, y, eq, er, ed, eo);
      out_ready = ($urandom_range(0, 1) != 0);
      issue(x, y, lat, rl, gq, gr, gd, go);
      checks++;
      if (lat != LAT || rl !== 1'b1 || gq !== eq || gr !== er || gd !== ed || go !== eo)
        $display("FAIL random_%0d (%0d/%0d): lat=%0d q=%0d r=%0d dbz=%b ovf=%b, required lat=%0d q=%0d r=%0d dbz=%b ovf=%b",
                 n, x, y, lat, gq, gr, gd, go, LAT, eq, er, ed, eo);
      else passed++;
      stall = $urandom_range(0, 3);
      if (stall > 0) begin
        out_ready = 1'b0;
        repeat (stall) @(negedge clk);
      end
      release_out();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
